decodificador_varredura_n: RTL and testbench
============================================

Name: decodificador_varredura_n

Overview:
- Parametrised successor to the 2-to-4 active-low decoder.
- Decodes an SEL_W-bit index into 2**SEL_W active-low, registered, one-hot-low outputs.
- Two modes:
  - Manual: the index comes from the sel_in port.
  - Auto-scan: an internal prescaled counter steps the index for multiplexed 7-segment digit selection.
- An optional blanking gap after each step prevents ghosting.
- Sits between the display data mux and the FPGA digit-enable pins.

Parameters:
- SEL_W, 2, index width; output count N = 2**SEL_W (legal 1..5).
- PRESCALE, 50000, clock cycles per scan step in auto mode (legal >= 2).
- BLANK, 0, all-ones cycles inserted after each auto step (legal 0..PRESCALE-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  enable; 0 forces all outputs high (inactive).
- mode  in  1  0 = manual (index from sel_in), 1 = auto-scan.
- sel_in  in  SEL_W  manual index.
- Y  out  N  active-low decoded outputs; Y[i] = 0 selects output i.
- sel_out  out  SEL_W  current registered index (drives the data mux).
- tick  out  1  one-cycle pulse when the auto index advances.

Behaviour:
- Registers: idx (SEL_W), pcnt (prescaler, width clog2(PRESCALE)), bcnt (blank counter), Y, tick.
- Reset (rst_n = 0, asynchronous): idx = 0, pcnt = 0, bcnt = 0, tick = 0, Y = all ones, sel_out = 0. Registers update on the first clk edge after release.
- Output register, every cycle:
  - If en = 1 and bcnt = 0, Y <= ~(1 << idx).
  - Otherwise Y <= all ones.
  - Uses pre-edge values of idx and bcnt.
- sel_out = idx (direct).
- Manual (en = 1, mode = 0):
  - idx <= sel_in; pcnt <= 0; bcnt <= 0; tick <= 0.
  - Latency: sel_in sampled at edge k, idx valid after k, Y valid after edge k+1, i.e. 2 cycles.
- Auto (en = 1, mode = 1):
  - If pcnt = PRESCALE-1: pcnt <= 0, idx <= idx+1 modulo N (N-1 wraps to 0), tick <= 1, bcnt <= BLANK.
  - Else: pcnt <= pcnt+1, tick <= 0, and bcnt <= bcnt-1 if nonzero.
  - Period per index: exactly PRESCALE cycles. Y all-ones for BLANK cycles at the start of each step.
- Disabled (en = 0): idx holds; pcnt <= 0; bcnt <= 0; tick <= 0; Y <= all ones next edge.
  - Re-enabling in auto restarts a full PRESCALE period from the held idx.
- Mode changes:
  - Auto -> manual: idx loads sel_in on the next edge. Pending blank is cancelled (bcnt <= 0).
  - Manual -> auto: scan starts from the current idx with pcnt = 0.
- Arithmetic: idx increment is unsigned, modulo 2**SEL_W. No out-of-range index exists.
- Reset asserted mid-scan or mid-blank: all state is cleared immediately, regardless of clk.
- Y is never X after reset. Exactly one bit is low or all bits are high; never two bits low.

Test Plan (SEL_W=2, PRESCALE=4, BLANK=1 unless stated):
- Reset:
  - Stimulus: hold rst_n=0 with mode=1, en=1, clk running.
  - Response: Y=4'b1111, sel_out=0, tick=0 throughout. After release, first Y=4'b1110 one edge later.
- Manual decode:
  - Stimulus: mode=0, en=1, sel_in = 0, 1, 2, 3 each held 3 cycles.
  - Response: Y = 1110, 1101, 1011, 0111, each appearing 2 edges after the sel_in change.
  - Stimulus: en=0.
  - Response: Y=1111 next edge.
- Auto scan and wrap:
  - Stimulus: mode=1, en=1 for 20 cycles.
  - Response: tick every 4 cycles; sel_out 0->1->2->3->0. After each tick, Y=1111 for 1 cycle then the decoded value for 3 cycles. 3->0 wrap verified.
- BLANK=0 variant:
  - Response: no all-ones cycles in auto; each index holds 4 cycles.
- Enable/mode interactions:
  - Stimulus: drop en mid-step at pcnt=2, sel_out=2.
  - Response: Y=1111, sel_out stays 2. Re-enable: 4 full cycles before the tick to 3.
  - Stimulus: switch to mode=0 with sel_in=1 during blank.
  - Response: blank cancelled, Y=1101 two edges later.
- Async reset mid-operation:
  - Stimulus: pulse rst_n low between clk edges while sel_out=3.
  - Response: Y=1111 and sel_out=0 immediately, before the next edge.

Source files
------------

// File: rtl/decodificador_varredura_n.sv
// Parametrised active-low one-hot decoder with manual index or prescaled auto-scan,
// optional blanking gap after each scan step; all outputs registered.
module decodificador_varredura_n #(
    parameter int SEL_W    = 2,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel_in,
    output logic [(2**SEL_W)-1:0]   Y,
    output logic [SEL_W-1:0]        sel_out,
    output logic                    tick
);

    localparam int N  = 2**SEL_W;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0]    PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    BLANK_LD  = PW'(BLANK);
    localparam logic [PW-1:0]    CNT_ONE   = PW'(1);
    localparam logic [SEL_W-1:0] IDX_ONE   = SEL_W'(1);
    localparam logic [N-1:0]     Y_ONE     = N'(1);

    logic [SEL_W-1:0] r_idx;
    logic [PW-1:0]    r_pcnt;
    logic [PW-1:0]    r_bcnt;
    logic [N-1:0]     r_y;
    logic             r_tick;

    logic [SEL_W-1:0] w_idx_nxt;
    logic [PW-1:0]    w_pcnt_nxt;
    logic [PW-1:0]    w_bcnt_nxt;
    logic [N-1:0]     w_y_nxt;
    logic             w_tick_nxt;

    // Next-state for index, prescaler, blank counter and the decoded output word
    always_comb begin
        w_idx_nxt  = r_idx;
        w_pcnt_nxt = r_pcnt;
        w_bcnt_nxt = r_bcnt;
        w_tick_nxt = 1'b0;

        // Decode uses the pre-edge index, so Y trails idx by one cycle
        if (en && (r_bcnt == '0)) begin
            w_y_nxt = ~(Y_ONE << r_idx);
        end else begin
            w_y_nxt = '1;
        end

        if (!en) begin
            w_pcnt_nxt = '0;
            w_bcnt_nxt = '0;
        end else if (!mode) begin
            w_idx_nxt  = sel_in;
            w_pcnt_nxt = '0;
            w_bcnt_nxt = '0;
        end else if (r_pcnt == PCNT_LAST) begin
            w_pcnt_nxt = '0;
            w_idx_nxt  = r_idx + IDX_ONE;
            w_tick_nxt = 1'b1;
            w_bcnt_nxt = BLANK_LD;
        end else begin
            w_pcnt_nxt = r_pcnt + CNT_ONE;
            if (r_bcnt != '0) begin
                w_bcnt_nxt = r_bcnt - CNT_ONE;
            end else begin
                w_bcnt_nxt = r_bcnt;
            end
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_pcnt <= '0;
            r_bcnt <= '0;
            r_y    <= '1;
            r_tick <= 1'b0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_pcnt <= w_pcnt_nxt;
            r_bcnt <= w_bcnt_nxt;
            r_y    <= w_y_nxt;
            r_tick <= w_tick_nxt;
        end
    end

    assign Y       = r_y;
    assign sel_out = r_idx;
    assign tick    = r_tick;

endmodule

// File: tb/tb_decodificador_varredura_n.sv
// Scoreboard bench: directed vectors push hand-computed expectations, monitors pop
// and compare after each clock edge (or after an asynchronous reset pulse).
module tb_decodificador_varredura_n;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [1:0] sel_in;
    logic [3:0] y_a, y_b;
    logic [1:0] sel_a, sel_b;
    logic       tick_a, tick_b;

    decodificador_varredura_n #(.SEL_W(2), .PRESCALE(4), .BLANK(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
        .Y(y_a), .sel_out(sel_a), .tick(tick_a)
    );

    decodificador_varredura_n #(.SEL_W(2), .PRESCALE(4), .BLANK(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
        .Y(y_b), .sel_out(sel_b), .tick(tick_b)
    );

    typedef struct {
        int         which;
        int         id;
        logic [3:0] y;
        logic [1:0] sel;
        logic       tick;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   vid      = 0;
    event ev_async;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input exp_t e);
        logic [3:0] ay;
        logic [1:0] as;
        logic       at;
        ay = (e.which == 0) ? y_a    : y_b;
        as = (e.which == 0) ? sel_a  : sel_b;
        at = (e.which == 0) ? tick_a : tick_b;
        checks++;
        if ((ay !== e.y) || (as !== e.sel) || (at !== e.tick)) begin
            failures++;
            $display("FAIL vec%0d dut%0d: got Y=%b sel_out=%0d tick=%b, expected Y=%b sel_out=%0d tick=%b",
                     e.id, e.which, ay, as, at, e.y, e.sel, e.tick);
        end
    endtask

    task automatic push(input int which, input logic [3:0] y, input logic [1:0] s, input logic t);
        exp_t e;
        e.which = which;
        e.id    = vid;
        e.y     = y;
        e.sel   = s;
        e.tick  = t;
        vid++;
        sbq.push_back(e);
    endtask

    // Drive inputs on the falling edge; expectation is for outputs after the next rising edge
    task automatic cyc(input logic r, input logic e_, input logic m, input logic [1:0] s,
                       input int which, input logic [3:0] y, input logic [1:0] so, input logic t);
        @(negedge clk);
        rst_n  = r;
        en     = e_;
        mode   = m;
        sel_in = s;
        push(which, y, so, t);
    endtask

    // Clock-edge monitor
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) compare(sbq.pop_front());
    end

    // Asynchronous-reset monitor
    always @(ev_async) begin
        #1;
        if (sbq.size() > 0) compare(sbq.pop_front());
    end

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        mode   = 1'b0;
        sel_in = 2'd0;

        // Reset held with auto mode enabled
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 2'd0, 0, 4'b1111, 2'd0, 1'b0);

        // Auto scan, BLANK=1: 20 cycles including the 3->0 wrap
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1110, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1110, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1110, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1110, 2'd1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1111, 2'd1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1101, 2'd1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1101, 2'd1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1101, 2'd2, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1111, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1011, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1011, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1011, 2'd3, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1111, 2'd3, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b0111, 2'd3, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b0111, 2'd3, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b0111, 2'd0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1111, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1110, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1110, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1110, 2'd1, 1'b1);

        // Manual decode, entered during a blank cycle
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 0, 4'b1111, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 0, 4'b1110, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 0, 4'b1110, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd1, 0, 4'b1110, 2'd1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd1, 0, 4'b1101, 2'd1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd1, 0, 4'b1101, 2'd1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd2, 0, 4'b1101, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd2, 0, 4'b1011, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd2, 0, 4'b1011, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd3, 0, 4'b1011, 2'd3, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd3, 0, 4'b0111, 2'd3, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd3, 0, 4'b0111, 2'd3, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 0, 4'b1111, 2'd3, 1'b0);

        // Enable drop at pcnt=2 / index 2, then re-enable and blank cancel
        cyc(1'b1, 1'b1, 1'b0, 2'd2, 0, 4'b0111, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd2, 0, 4'b1011, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1011, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1011, 2'd2, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 2'd0, 0, 4'b1111, 2'd2, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 2'd0, 0, 4'b1111, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1011, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1011, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1011, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 0, 4'b1011, 2'd3, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 2'd1, 0, 4'b1111, 2'd1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd1, 0, 4'b1101, 2'd1, 1'b0);

        // Asynchronous reset between edges while index is 3
        cyc(1'b1, 1'b1, 1'b0, 2'd3, 0, 4'b1101, 2'd3, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd3, 0, 4'b0111, 2'd3, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        push(0, 4'b1111, 2'd0, 1'b0);
        -> ev_async;
        cyc(1'b0, 1'b1, 1'b0, 2'd2, 0, 4'b1111, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd2, 0, 4'b1110, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd2, 0, 4'b1011, 2'd2, 1'b0);

        // BLANK=0 instance: no all-ones cycles, 4 cycles per index
        cyc(1'b0, 1'b1, 1'b1, 2'd0, 1, 4'b1111, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 1, 4'b1110, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 1, 4'b1110, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 1, 4'b1110, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 1, 4'b1110, 2'd1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 1, 4'b1101, 2'd1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 1, 4'b1101, 2'd1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 1, 4'b1101, 2'd1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 1, 4'b1101, 2'd2, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 1, 4'b1011, 2'd2, 1'b0);

        @(posedge clk);
        #3;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
